// File: rtl/ans_freq_table.sv
`default_nettype none
// ============================================================================
// Module   : ans_freq_table
// Purpose  : Symbol-to-frequency lookup stage feeding the ANS encoder.
//            Holds a programmable per-symbol count table. A sequential
//            prefix-sum scan builds the cumulative table and the total count.
//            In run mode each accepted symbol is turned into a
//            (count, cumulative) pair on a valid/ready output register.
// Macros   : SYM_WIDTH   - symbol width, alphabet size N = 2**SYM_WIDTH
//            CNT_WIDTH   - per-symbol count width
//            STATE_WIDTH - total_count width
//            ANS_ZERO_COUNT_CHECK_EN - when defined, zero-count symbols are
//            consumed without being forwarded and raise a sticky o_err.
// Ports    : clk, rst_n          clock / async active-low reset
//            i_ena               global enable (0 freezes every register)
//            i_cfg_we/_sym/_count table write (LOAD only)
//            i_cfg_go            start the scan (LOAD only)
//            i_cfg_reload        level request to return from RUN to LOAD
//            o_table_rdy         high while in RUN
//            i_in_sym/_vld, o_in_rdy            input handshake
//            o_s_count/_cumulative, o_total_count lookup results
//            o_out_vld, i_out_rdy               output handshake
//            o_err               sticky zero-count error
// Revision : 1.0 - initial release
// ============================================================================

`ifndef SYM_WIDTH
`define SYM_WIDTH 2
`endif
`ifndef CNT_WIDTH
`define CNT_WIDTH 4
`endif
`ifndef STATE_WIDTH
`define STATE_WIDTH 12
`endif

module ans_freq_table (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              i_ena,
  input  logic                              i_cfg_we,
  input  logic [`SYM_WIDTH-1:0]             i_cfg_sym,
  input  logic [`CNT_WIDTH-1:0]             i_cfg_count,
  input  logic                              i_cfg_go,
  input  logic                              i_cfg_reload,
  output logic                              o_table_rdy,
  input  logic [`SYM_WIDTH-1:0]             i_in_sym,
  input  logic                              i_in_vld,
  output logic                              o_in_rdy,
  output logic [`CNT_WIDTH-1:0]             o_s_count,
  output logic [`SYM_WIDTH+`CNT_WIDTH-1:0]  o_s_cumulative,
  output logic [`STATE_WIDTH-1:0]           o_total_count,
  output logic                              o_out_vld,
  input  logic                              i_out_rdy,
  output logic                              o_err
);

  localparam int c_sym_w   = `SYM_WIDTH;
  localparam int c_cnt_w   = `CNT_WIDTH;
  localparam int c_state_w = `STATE_WIDTH;
  localparam int c_acc_w   = c_sym_w + c_cnt_w;
  localparam int c_n       = 1 << c_sym_w;

  localparam logic [c_sym_w-1:0] c_idx_one  = c_sym_w'(1);
  localparam logic [c_sym_w-1:0] c_idx_last = '1;

`ifdef ANS_ZERO_COUNT_CHECK_EN
  localparam bit c_zc_en = 1'b1;
`else
  localparam bit c_zc_en = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_SCAN = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t                r_state;
  logic [c_cnt_w-1:0]    r_count [c_n];
  logic [c_acc_w-1:0]    r_cum   [c_n];
  logic [c_sym_w-1:0]    r_idx;
  logic [c_acc_w-1:0]    r_acc;
  logic [c_state_w-1:0]  r_total;
  logic [c_cnt_w-1:0]    r_s_count;
  logic [c_acc_w-1:0]    r_s_cum;
  logic                  r_out_vld;
  logic                  r_table_rdy;
  logic                  r_err;

  logic [c_acc_w-1:0]          w_acc_next;
  logic [c_acc_w+c_state_w-1:0] w_acc_wide;
  logic [c_state_w-1:0]        w_total_next;
  logic [c_cnt_w-1:0]          w_lu_count;
  logic [c_acc_w-1:0]          w_lu_cum;
  logic                        w_in_rdy;
  logic                        w_accept;
  logic                        w_drop;

  // Scan accumulator step; the accumulator is wide enough to never overflow.
  assign w_acc_next = r_acc + {{c_sym_w{1'b0}}, r_count[r_idx]};

  // Zero-extend before slicing so the total is correct whether STATE_WIDTH
  // is wider or narrower than the accumulator (narrower truncates to LSBs).
  assign w_acc_wide   = {{c_state_w{1'b0}}, w_acc_next};
  assign w_total_next = w_acc_wide[c_state_w-1:0];

  assign w_lu_count = r_count[i_in_sym];
  assign w_lu_cum   = r_cum[i_in_sym];

  // A reload request closes the input so a pending output can drain first.
  assign w_in_rdy = (r_state == ST_RUN) && !i_cfg_reload && (!r_out_vld || i_out_rdy);
  assign w_accept = i_ena && i_in_vld && w_in_rdy;

  // Zero-count symbols are swallowed only when the check is built in.
  assign w_drop = c_zc_en && (w_lu_count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_LOAD;
      r_idx       <= '0;
      r_acc       <= '0;
      r_total     <= '0;
      r_s_count   <= '0;
      r_s_cum     <= '0;
      r_out_vld   <= 1'b0;
      r_table_rdy <= 1'b0;
      r_err       <= 1'b0;
      for (int i = 0; i < c_n; i++) begin
        r_count[i] <= '0;
        r_cum[i]   <= '0;
      end
    end else if (i_ena) begin
      case (r_state)
        ST_LOAD: begin
          if (i_cfg_we) begin
            r_count[i_cfg_sym] <= i_cfg_count;
          end
          // A write in the same cycle as go lands before the scan reads it.
          if (i_cfg_go) begin
            r_state <= ST_SCAN;
            r_idx   <= '0;
            r_acc   <= '0;
          end
        end

        ST_SCAN: begin
          r_cum[r_idx] <= r_acc;
          r_acc        <= w_acc_next;
          r_idx        <= r_idx + c_idx_one;
          if (r_idx == c_idx_last) begin
            r_total     <= w_total_next;
            r_state     <= ST_RUN;
            r_table_rdy <= 1'b1;
          end
        end

        ST_RUN: begin
          if (w_accept) begin
            if (w_drop) begin
              // Any previous output drained this cycle (accept implies it).
              r_out_vld <= 1'b0;
              r_err     <= 1'b1;
            end else begin
              r_s_count <= w_lu_count;
              r_s_cum   <= w_lu_cum;
              r_out_vld <= 1'b1;
            end
          end else if (r_out_vld && i_out_rdy) begin
            r_out_vld <= 1'b0;
          end else if (i_cfg_reload && !r_out_vld) begin
            // Table contents are kept; only changed entries need rewriting.
            r_state     <= ST_LOAD;
            r_table_rdy <= 1'b0;
            r_err       <= 1'b0;
          end
        end

        default: begin
          r_state     <= ST_LOAD;
          r_table_rdy <= 1'b0;
        end
      endcase
    end
  end

  assign o_table_rdy    = r_table_rdy;
  assign o_in_rdy       = w_in_rdy;
  assign o_s_count      = r_s_count;
  assign o_s_cumulative = r_s_cum;
  assign o_total_count  = r_total;
  assign o_out_vld      = r_out_vld;
  assign o_err          = r_err;

endmodule

`default_nettype wire

// File: tb/tb_ans_freq_table.sv
`default_nettype none
// ============================================================================
// Module   : tb_ans_freq_table
// Purpose  : Self-checking bench for ans_freq_table (SYM=2, CNT=4, STATE=12).
//            Lookup vectors come from hand-derived tables; expected results
//            are queued on accept and compared when the output transfers.
// Revision : 1.0 - initial release
// ============================================================================

`ifndef SYM_WIDTH
`define SYM_WIDTH 2
`endif
`ifndef CNT_WIDTH
`define CNT_WIDTH 4
`endif
`ifndef STATE_WIDTH
`define STATE_WIDTH 12
`endif

module tb_ans_freq_table;

`ifdef ANS_ZERO_COUNT_CHECK_EN
  localparam bit ZC = 1'b1;
`else
  localparam bit ZC = 1'b0;
`endif

  typedef struct packed {
    logic [`SYM_WIDTH-1:0]            sym;
    logic [`CNT_WIDTH-1:0]            cnt;
    logic [`SYM_WIDTH+`CNT_WIDTH-1:0] cum;
  } vec_t;

  logic                              clk;
  logic                              rst_n;
  logic                              ena;
  logic                              cfg_we;
  logic [`SYM_WIDTH-1:0]             cfg_sym;
  logic [`CNT_WIDTH-1:0]             cfg_count;
  logic                              cfg_go;
  logic                              cfg_reload;
  logic                              table_rdy;
  logic [`SYM_WIDTH-1:0]             in_sym;
  logic                              in_vld;
  logic                              in_rdy;
  logic [`CNT_WIDTH-1:0]             s_count;
  logic [`SYM_WIDTH+`CNT_WIDTH-1:0]  s_cum;
  logic [`STATE_WIDTH-1:0]           total_count;
  logic                              out_vld;
  logic                              out_rdy;
  logic                              err;

  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t exp_q[$];
  vec_t tab1 [4];
  vec_t tab2 [4];

  ans_freq_table dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_ena         (ena),
    .i_cfg_we      (cfg_we),
    .i_cfg_sym     (cfg_sym),
    .i_cfg_count   (cfg_count),
    .i_cfg_go      (cfg_go),
    .i_cfg_reload  (cfg_reload),
    .o_table_rdy   (table_rdy),
    .i_in_sym      (in_sym),
    .i_in_vld      (in_vld),
    .o_in_rdy      (in_rdy),
    .o_s_count     (s_count),
    .o_s_cumulative(s_cum),
    .o_total_count (total_count),
    .o_out_vld     (out_vld),
    .i_out_rdy     (out_rdy),
    .o_err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Output-side scoreboard: compare whenever a transfer happens.
  always @(negedge clk) begin
    if (rst_n && ena && out_vld && out_rdy) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output: got (%0d,%0d) expected none", s_count, s_cum);
      end else begin
        vec_t e;
        e = exp_q.pop_front();
        chk("out_count", 32'(s_count), 32'(e.cnt));
        chk("out_cum", 32'(s_cum), 32'(e.cum));
      end
    end
  end

  // Drive one symbol and wait (bounded) for it to be accepted.
  task automatic send(input vec_t v);
    bit done;
    done   = 1'b0;
    in_sym = v.sym;
    in_vld = 1'b1;
    for (int k = 0; k < 50 && !done; k++) begin
      #1;
      if (in_rdy) begin
        if (!(ZC && v.cnt == '0)) exp_q.push_back(v);
        done = 1'b1;
      end
      tick();
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: got in_rdy=0 expected accept of sym %0d", v.sym);
    end
  endtask

  task automatic wait_table_rdy();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      if (table_rdy) seen = 1'b1;
      else tick();
    end
    chk("table_rdy_wait", 32'(seen), 32'd1);
  endtask

  task automatic write_cfg(input int sym, input int cnt, input bit go);
    cfg_we    = 1'b1;
    cfg_sym   = `SYM_WIDTH'(sym);
    cfg_count = `CNT_WIDTH'(cnt);
    cfg_go    = go;
    tick();
    cfg_we = 1'b0;
    cfg_go = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // counts {3,1,0,4} -> cum {0,3,4,4}; then sym1=5 -> cum {0,3,8,8}
    tab1[0] = '{sym: 2'd0, cnt: 4'd3, cum: 6'd0};
    tab1[1] = '{sym: 2'd1, cnt: 4'd1, cum: 6'd3};
    tab1[2] = '{sym: 2'd2, cnt: 4'd0, cum: 6'd4};
    tab1[3] = '{sym: 2'd3, cnt: 4'd4, cum: 6'd4};
    tab2[0] = '{sym: 2'd0, cnt: 4'd3, cum: 6'd0};
    tab2[1] = '{sym: 2'd1, cnt: 4'd5, cum: 6'd3};
    tab2[2] = '{sym: 2'd2, cnt: 4'd0, cum: 6'd8};
    tab2[3] = '{sym: 2'd3, cnt: 4'd4, cum: 6'd8};

    rst_n = 1'b0; ena = 1'b1; cfg_we = 1'b0; cfg_sym = '0; cfg_count = '0;
    cfg_go = 1'b0; cfg_reload = 1'b0; in_sym = '0; in_vld = 1'b0; out_rdy = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    tick(); #1;
    chk("rst_out_vld", 32'(out_vld), 0);
    chk("rst_in_rdy", 32'(in_rdy), 0);
    chk("rst_table_rdy", 32'(table_rdy), 0);
    chk("rst_total", 32'(total_count), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_s_count", 32'(s_count), 0);

    // Load table; a duplicate write to sym0 checks last-write-wins, and the
    // final write shares its cycle with go.
    write_cfg(0, 9, 1'b0);
    write_cfg(0, 3, 1'b0);
    write_cfg(1, 1, 1'b0);
    write_cfg(2, 0, 1'b0);
    write_cfg(3, 4, 1'b1);          // go accepted at this edge (t)
    tick(); tick(); tick();         // now just after edge t+3
    chk("table_rdy_early", 32'(table_rdy), 0);
    chk("in_rdy_in_scan", 32'(in_rdy), 0);
    tick();                         // after edge t+4 -> RUN
    chk("table_rdy_on_time", 32'(table_rdy), 1);
    chk("total_8", 32'(total_count), 8);

    // Back-to-back stream 3,0,1 with out_rdy=1.
    send(tab1[3]);
    send(tab1[0]);
    chk("b2b_vld0", 32'(out_vld), 1);
    send(tab1[1]);
    chk("b2b_vld1", 32'(out_vld), 1);
    in_vld = 1'b0;
    tick(); tick();
    chk("b2b_drained", 32'(exp_q.size()), 0);

    // Backpressure: first result must hold while out_rdy=0.
    out_rdy = 1'b0;
    send(tab1[3]);
    in_sym = 2'd0;
    in_vld = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_in_rdy", 32'(in_rdy), 0);
      chk("bp_vld", 32'(out_vld), 1);
      chk("bp_hold_count", 32'(s_count), 4);
      chk("bp_hold_cum", 32'(s_cum), 4);
      tick();
    end
    out_rdy = 1'b1;
    send(tab1[0]);
    send(tab1[1]);
    in_vld = 1'b0;
    tick(); tick();
    chk("bp_drained", 32'(exp_q.size()), 0);

    // Zero-count symbol.
    send(tab1[2]);
    in_vld = 1'b0;
    tick(); tick();
    chk("zero_vld", 32'(out_vld), 0);
    chk("zero_err", 32'(err), 32'(ZC));
    chk("zero_drained", 32'(exp_q.size()), 0);

    // Reload while an output is pending.
    out_rdy = 1'b0;
    send(tab1[3]);
    in_vld = 1'b0;
    cfg_reload = 1'b1;
    tick(); tick(); #1;
    chk("rl_stay_run", 32'(table_rdy), 1);
    chk("rl_in_rdy", 32'(in_rdy), 0);
    chk("rl_vld_held", 32'(out_vld), 1);
    chk("rl_err_held", 32'(err), 32'(ZC));
    out_rdy = 1'b1;
    tick();                          // drain
    tick();                          // enter LOAD
    chk("rl_in_load", 32'(table_rdy), 0);
    chk("rl_err_clr", 32'(err), 0);
    cfg_reload = 1'b0;
    write_cfg(1, 5, 1'b1);
    wait_table_rdy();
    chk("total_12", 32'(total_count), 12);
    for (int i = 0; i < 4; i++) send(tab2[i]);
    in_vld = 1'b0;
    tick(); tick();
    chk("tab2_drained", 32'(exp_q.size()), 0);
    chk("tab2_err", 32'(err), 32'(ZC));

    // ena=0 freezes the pending output even with out_rdy=1.
    out_rdy = 1'b0;
    send(tab2[3]);
    in_vld = 1'b0;
    ena = 1'b0;
    out_rdy = 1'b1;
    tick(); tick();
    chk("ena_hold_vld", 32'(out_vld), 1);
    chk("ena_hold_total", 32'(total_count), 12);
    ena = 1'b1;
    tick(); tick();
    chk("ena_drained", 32'(exp_q.size()), 0);
    chk("ena_vld_low", 32'(out_vld), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
